// File: rtl/pl_pkg.sv
// Shared constants for the handshaked pipeline stage register family.
package pl_pkg;

   localparam int PL_DATA_W = 32;
   localparam int PL_CNT_W  = 16;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module pl_sat_counter
   import pl_pkg::*;
#(
   parameter int W = PL_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pl_stage_hs.sv
// Valid/ready pipeline stage register with optional skid entry, flush and
// a saturating stall-cycle counter. Outputs come straight from the main entry.
module pl_stage_hs
   import pl_pkg::*;
#(
   parameter int DATA_W = PL_DATA_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = PL_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              cnt_clr
);

   logic              main_v_q, main_v_d;
   logic              skid_v_q, skid_v_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              up_xfer;
   logic              dn_xfer;

   always_comb begin
      if (SKID != 0) begin
         in_ready = !skid_v_q;
      end else begin
         in_ready = !main_v_q || out_ready;
      end
   end

   assign up_xfer = in_valid && in_ready;
   assign dn_xfer = main_v_q && out_ready;

   always_comb begin
      main_v_d    = main_v_q;
      skid_v_d    = skid_v_q;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      // Flush drops valids only; payload flops keep their stale contents.
      if (flush_i) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (SKID == 0) begin
         if (up_xfer) begin
            main_v_d    = 1'b1;
            main_data_d = in_data;
         end else if (dn_xfer) begin
            main_v_d = 1'b0;
         end
      end else begin
         // in_ready is low whenever skid is full, so no upstream load here.
         if (dn_xfer && skid_v_q) begin
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
         end else if (up_xfer && (!main_v_q || dn_xfer)) begin
            main_v_d    = 1'b1;
            main_data_d = in_data;
         end else if (up_xfer) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
         end else if (dn_xfer) begin
            main_v_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v_q    <= 1'b0;
         skid_v_q    <= 1'b0;
         main_data_q <= '0;
         skid_data_q <= '0;
      end else begin
         main_v_q    <= main_v_d;
         skid_v_q    <= skid_v_d;
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
      end
   end

   always_comb begin
      unique case ({main_v_q, skid_v_q})
         2'b00:   occupancy = OCC_EMPTY;
         2'b11:   occupancy = OCC_FULL;
         default: occupancy = OCC_ONE;
      endcase
   end

   assign out_valid = main_v_q;
   assign out_data  = main_data_q;

   pl_sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (main_v_q && !out_ready),
      .clr  (cnt_clr),
      .cnt  (stall_cnt)
   );

endmodule

// File: doc/pl_stage_hs.md
Name: pl_stage_hs

Overview:
- Parametrised pipeline stage register with a valid/ready handshake. It is the successor to the fixed execute|memory stage registers.
- Carries an opaque DATA_W payload between any two pipeline stages.
- Adds an optional skid entry for full throughput under back-pressure, a flush that outranks everything, and a saturating stall-cycle counter for performance monitoring.
- Instantiated between EX/MEM and MEM/WB in place of en/clr-style stage registers.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- SKID, 1, 1 = two-entry stage (main + skid), in_ready registered; 0 = single entry, in_ready combinational from out_ready.
- CNT_W, 16, width of the stall counter (≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents a payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  presented payload.
- occupancy  out  2  entries held (0..2; 0..1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- cnt_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Main and skid valid bits = 0; main and skid data = 0.
  - stall_cnt = 0.
  - Resulting outputs: out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Handshake:
  - Upstream transfer when in_valid && in_ready.
  - Downstream transfer when out_valid && out_ready.
  - out_data and out_valid come straight from main-entry flops; no combinational path from in_* to out_*.
  - out_data must hold stable while out_valid && !out_ready.
- Latency: a payload accepted at edge N is presented at out_* after edge N (one cycle) when the stage was empty.
- SKID=0:
  - in_ready = !main_v || out_ready.
  - On an upstream transfer, main loads in_data and main_v is set. Otherwise, on a downstream transfer, main_v is cleared.
- SKID=1:
  - in_ready = !skid_v (registered).
  - Upstream transfer with main empty, or main draining this cycle: load main, skid untouched.
  - Upstream transfer with main full and not draining: load skid.
  - Downstream transfer with skid_v: skid moves to main, skid_v cleared (same edge may reload skid only if skid was empty, which is impossible here, so no).
  - Back-to-back throughput is 1 payload/cycle with out_ready held high.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Flush (flush_i=1 at an edge):
  - main_v and skid_v are cleared.
  - Any simultaneous upstream transfer is discarded.
  - Data flops keep their values; only valids are cleared.
  - in_ready still follows its rule in the flush cycle (upstream may believe it transferred; the payload is dropped by design).
- occupancy = main_v + skid_v.
- stall_cnt:
  - Increments by 1 each edge with out_valid && !out_ready.
  - Saturates at 2^CNT_W−1.
  - cnt_clr forces 0 and wins over increment.
  - flush_i does not affect it.
- Reset mid-transfer: all in-flight payloads are lost immediately, with no glitch-free guarantee on out_data during reset assertion.
- Assertions for the bench:
  - occupancy never exceeds 1+SKID.
  - in_ready=0 implies occupancy=1+SKID.

Decomposition:
- pl_pkg: default widths (PL_DATA_W=32, PL_CNT_W=16) and the occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
- One sub-module, pl_sat_counter (parameter W; ports clk, rst_n, inc, clr, cnt), used for stall_cnt and reusable for other pipeline performance counters.

Test Plan:
- Reset then idle (SKID=1): rst_n low mid-run holding 2 entries → immediately out_valid=0, occupancy=0, out_data=0, stall_cnt=0; after release in_ready=1.
- Streaming: out_ready=1, in_valid=1, in_data=0x1,0x2,…,0x10 on consecutive cycles → out_data 0x1..0x10 on 16 consecutive cycles, one cycle after input, stall_cnt=0.
- Back-pressure (SKID=1): send 0xA,0xB,0xC with out_ready=0 → 0xA, 0xB accepted, in_ready=0 after second accept, occupancy=2, 0xC held upstream. Raise out_ready → outputs 0xA,0xB,0xC in order, no loss or duplicate.
- Same as above with SKID=0 → in_ready drops combinationally with out_ready=0 and main full; order preserved; occupancy ≤1.
- Flush: occupancy=2 plus a simultaneous upstream transfer 0xD with flush_i=1 → next cycle occupancy=0, out_valid=0, 0xD never appears.
- Counter: hold out_valid with out_ready=0 for 5 cycles → stall_cnt=5. Assert cnt_clr together with a stall → 0. With CNT_W=2, stall 6 cycles → stall_cnt=3 (saturated).
